// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch-side branch controller:
// opcodes, the halt instruction, FSM states and the reset contents of the branch-target LUT.
package fetch_pkg;

  localparam logic [2:0] BR_OPC     = 3'b110;
  localparam logic [2:0] JMP_OPC    = 3'b101;
  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  localparam int LUT_ENTRIES = 8;
  localparam int LUT_AW      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [15:0] lut_init_t [LUT_ENTRIES];

  localparam lut_init_t LUT_INIT = '{
    16'd0, 16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24, 16'd28
  };

  function automatic logic [2:0] opcode_of(input logic [8:0] instr);
    return instr[8:6];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: synchronous write, asynchronous read, and a
// synchronous reset that reloads the default targets from fetch_pkg.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              init,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];

  // NOTE: mem_d starts as a copy of mem_q so every path assigns it and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // NOTE: every entry is reset on purpose: the LUT is a handful of flops that must
  // return to known default targets, which a RAM macro could not do.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PC_W'(LUT_INIT[i]);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-write contents during a write cycle: there is no bypass.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch/halt controller for the program counter: IDLE/RUN/DONE handshake,
// branch decode against a loadable target LUT, and a saturating run-cycle counter.
module branch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int TGT_W     = 16,
  parameter int LUT_DEPTH = 8,
  parameter int HALT_PC   = 63,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             Req,
  input  logic [PC_W-1:0]  PC,
  input  logic [8:0]       Instr,
  input  logic             ALU_zero,
  input  logic             LutWe,
  input  logic [2:0]       LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic             Branch_abs,
  output logic [TGT_W-1:0] Target,
  output logic             Halt,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_rdata;
  logic             halt_cond;

  branch_lut #(
    .PC_W  (PC_W),
    .DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk   (CLK),
    .init  (Init),
    .we    (LutWe),
    .waddr (LutAddr),
    .wdata (LutData),
    .raddr (Instr[2:0]),
    .rdata (lut_rdata)
  );

  assign halt_cond = (Instr == HALT_INSTR) || (PC == PC_W'(HALT_PC));

  // NOTE: state and counter flops use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Req)       state_d = RUN;
      RUN:     if (halt_cond) state_d = DONE;
      DONE:    if (!Req)      state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // The counter restarts on RUN entry, counts every RUN cycle including the
  // halting one, and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && Req) begin
      cnt_d = '0;
    end else if (state_q == RUN && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    Halt       = 1'b1;
    Branch_abs = 1'b0;
    if (state_q == RUN) begin
      Halt = halt_cond;
      // Halt takes priority over any branch on the same instruction.
      if (!halt_cond) begin
        unique case (opcode_of(Instr))
          BR_OPC:  Branch_abs = ALU_zero;
          JMP_OPC: Branch_abs = 1'b1;
          default: Branch_abs = 1'b0;
        endcase
      end
    end
  end

  assign Ack        = (state_q == DONE);
  assign Target     = TGT_W'(lut_rdata);
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: expected outputs are queued when stimulus is
// applied and compared mid-cycle; a narrow-counter instance checks saturation.
module tb_branch_ctrl;

  logic        CLK = 1'b0;
  logic        Init, Req, ALU_zero, LutWe;
  logic [9:0]  PC, LutData;
  logic [8:0]  Instr;
  logic [2:0]  LutAddr;

  logic        Branch_abs, Halt, Ack;
  logic [15:0] Target, CycleCount;
  logic        Branch_abs_s, Halt_s, Ack_s;
  logic [15:0] Target_s;
  logic [3:0]  CycleCount_s;

  typedef struct packed {
    logic        halt;
    logic        br;
    logic        ack;
    logic [15:0] tgt;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    string name;
    outs_t v;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 CLK = ~CLK;

  branch_ctrl u_dut (
    .CLK(CLK), .Init(Init), .Req(Req), .PC(PC), .Instr(Instr), .ALU_zero(ALU_zero),
    .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
    .Branch_abs(Branch_abs), .Target(Target), .Halt(Halt), .Ack(Ack),
    .CycleCount(CycleCount)
  );

  branch_ctrl #(.CNT_W(4)) u_dut_sat (
    .CLK(CLK), .Init(Init), .Req(Req), .PC(PC), .Instr(Instr), .ALU_zero(ALU_zero),
    .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
    .Branch_abs(Branch_abs_s), .Target(Target_s), .Halt(Halt_s), .Ack(Ack_s),
    .CycleCount(CycleCount_s)
  );

  function automatic outs_t obs_main();
    outs_t o;
    o.halt = Halt; o.br = Branch_abs; o.ack = Ack; o.tgt = Target; o.cnt = CycleCount;
    return o;
  endfunction

  function automatic outs_t obs_sat();
    outs_t o;
    o.halt = Halt_s; o.br = Branch_abs_s; o.ack = Ack_s; o.tgt = Target_s;
    o.cnt = {12'd0, CycleCount_s};
    return o;
  endfunction

  task automatic push_exp(input string name, input logic h, input logic b, input logic a,
                          input logic [15:0] t, input logic [15:0] c);
    sb_t e;
    e.name = name; e.v.halt = h; e.v.br = b; e.v.ack = a; e.v.tgt = t; e.v.cnt = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    Init = 1'b1; Req = 1'b0; PC = '0; Instr = '0; ALU_zero = 1'b0;
    LutWe = 1'b0; LutAddr = '0; LutData = '0;
    tick();
    Init = 1'b0;
    push_exp("reset_state", 1, 0, 0, 16'd0, 16'd0);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    push_exp("idle_stays", 1, 0, 0, 16'd0, 16'd0);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
  endtask

  task automatic test_run();
    sb_t e;
    tick();
    Req = 1'b1; PC = '0; Instr = 9'h003;
    push_exp("idle_req", 1, 0, 0, 16'd12, 16'd0);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    Req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      PC = 10'(k);
      Instr = (k == 5) ? 9'h1FF : 9'h003;
      if (k == 5) push_exp("halt_cycle", 1, 0, 0, 16'd28, 16'd5);
      else        push_exp("run_cycle", 0, 0, 0, 16'd12, 16'(k));
      @(negedge CLK);
      e = sb.pop_front(); n_checks++;
      if (obs_main() !== e.v) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, k, obs_main(), e.v);
      end
      tick();
    end
    Req = 1'b1;
    push_exp("done_ack", 1, 0, 1, 16'd28, 16'd6);
    push_exp("done_req_held", 1, 0, 1, 16'd28, 16'd6);
    push_exp("idle_after_done", 1, 0, 0, 16'd28, 16'd6);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      e = sb.pop_front(); n_checks++;
      if (obs_main() !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
      end
      tick();
      Req = 1'b0;
    end
  endtask

  task automatic test_branch();
    sb_t e;
    Instr = 9'b000_000_011; LutWe = 1'b1; LutAddr = 3'd3; LutData = 10'd40;
    push_exp("lut_no_bypass", 1, 0, 0, 16'd12, 16'd6);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    LutWe = 1'b0; Req = 1'b1;
    push_exp("lut_written", 1, 0, 0, 16'd40, 16'd6);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    Req = 1'b0; PC = 10'd1;
    for (int k = 0; k < 4; k++) begin
      Instr    = (k < 2) ? 9'b110_000_011 : 9'b101_000_011;
      ALU_zero = (k == 0 || k == 3);
      push_exp((k < 2) ? "br_cond" : "jmp", 0, (k != 1), 0, 16'd40, 16'(k));
      @(negedge CLK);
      e = sb.pop_front(); n_checks++;
      if (obs_main() !== e.v) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, k, obs_main(), e.v);
      end
      tick();
    end
  endtask

  task automatic test_halt_priority();
    sb_t e;
    PC = 10'd63; Instr = 9'b101_000_011; ALU_zero = 1'b1;
    push_exp("halt_beats_jmp", 1, 0, 0, 16'd40, 16'd4);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    PC = '0;
    push_exp("halt_to_done", 1, 0, 1, 16'd40, 16'd5);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    sb_t e;
    Instr = 9'h001; ALU_zero = 1'b0; LutWe = 1'b1; LutAddr = 3'd1; LutData = 10'd99;
    push_exp("lut1_old", 1, 0, 0, 16'd4, 16'd5);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    LutWe = 1'b0; Req = 1'b1;
    tick();
    Req = 1'b0; PC = 10'd2;
    for (int k = 0; k < 2; k++) begin
      push_exp("run_lut1", 0, 0, 0, 16'd99, 16'(k));
      @(negedge CLK);
      e = sb.pop_front(); n_checks++;
      if (obs_main() !== e.v) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, k, obs_main(), e.v);
      end
      tick();
    end
    Init = 1'b1;
    tick();
    Init = 1'b0;
    push_exp("mid_reset_idx1", 1, 0, 0, 16'd4, 16'd0);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
    Instr = 9'h003;
    push_exp("mid_reset_idx3", 1, 0, 0, 16'd12, 16'd0);
    @(negedge CLK);
    e = sb.pop_front(); n_checks++;
    if (obs_main() !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs_main(), e.v);
    end
    tick();
  endtask

  task automatic test_saturation();
    sb_t e;
    Req = 1'b1; PC = '0; Instr = 9'h003;
    tick();
    Req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      push_exp("sat_run", 0, 0, 0, 16'd12, 16'((k > 15) ? 15 : k));
      @(negedge CLK);
      e = sb.pop_front(); n_checks++;
      if (obs_sat() !== e.v) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, k, obs_sat(), e.v);
      end
      tick();
    end
    Instr = 9'h1FF;
    push_exp("sat_halt", 1, 0, 0, 16'd28, 16'd15);
    push_exp("sat_done", 1, 0, 1, 16'd28, 16'd15);
    push_exp("sat_idle_hold", 1, 0, 0, 16'd28, 16'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      e = sb.pop_front(); n_checks++;
      if (obs_sat() !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, obs_sat(), e.v);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_run();
    test_branch();
    test_halt_priority();
    test_mid_reset();
    test_saturation();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
